// File: rtl/keypad_encoder.sv
// keypad_encoder: synchronizes, debounces and priority-encodes 17 key lines into a 5-bit code plus strobe.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe a held key every REPEAT_CYCLES (clear key excluded).
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [16:0] in,
  output logic [4:0]  keyout,
  output logic        strobe,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, DEBOUNCE, FIRE, HELD, RELEASE} state_t;
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  state_t state, state_n;
  logic [16:0] meta, sync;
  logic [15:0] cnt, cnt_n;
  logic [4:0] cand, cand_n, enc, keyout_n;
  logic any, fire_rpt;
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_db_range
    $error("DEBOUNCE_CYCLES must be 1..65535");
  end
  if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > 65535) begin : g_rp_range
    $error("REPEAT_CYCLES must be 1..65535");
  end
  assign any = |sync;
  assign busy = state != IDLE;
  always_comb begin
    enc = '0;
    for (int i = 0; i < 17; i++) if (sync[i]) enc = 5'(i);
  end
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [15:0] RP_LAST = 16'(REPEAT_CYCLES - 1);
  logic [15:0] rcnt;
  assign fire_rpt = state == HELD && any && rcnt == RP_LAST && keyout != 5'd16;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) rcnt <= '0;
    else rcnt <= (state == HELD && state_n == HELD) ? rcnt + 16'd1 : '0;
`else
  assign fire_rpt = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cand_n = cand;
    keyout_n = keyout;
    case (state)
      IDLE: if (any) begin
        cand_n = enc;
        state_n = DEBOUNCE;
      end
      DEBOUNCE: if (!any || enc != cand) state_n = IDLE;
        else if (cnt == DB_LAST) begin
          keyout_n = cand;
          state_n = FIRE;
        end else cnt_n = cnt + 16'd1;
      FIRE: state_n = HELD;
      HELD: if (!any) state_n = RELEASE;
        else if (fire_rpt) state_n = FIRE;
      RELEASE: if (any) state_n = HELD;
        else if (cnt == DB_LAST) state_n = IDLE;
        else cnt_n = cnt + 16'd1;
      default: state_n = IDLE;
    endcase
    if (state_n != state) cnt_n = '0;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      meta <= '0;
      sync <= '0;
      state <= IDLE;
      cnt <= '0;
      cand <= '0;
      keyout <= '0;
      strobe <= 1'b0;
    end else begin
      meta <= in;
      sync <= meta;
      state <= state_n;
      cnt <= cnt_n;
      cand <= cand_n;
      keyout <= keyout_n;
      strobe <= state == FIRE;
    end
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: directed stimulus checked every cycle against a run-length model of the keypad rules.
module tb_keypad_encoder;
  localparam int D = 4;
  localparam int R = 16;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif
  logic clk = 1'b0;
  logic nrst;
  logic [16:0] in;
  logic [4:0] keyout;
  logic strobe, busy;
  int tests = 0, fails = 0, nstrb = 0;
  logic [4:0] seen[$];
  keypad_encoder #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .nrst(nrst), .in(in), .keyout(keyout), .strobe(strobe), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] win(logic [16:0] v);
    win = '0;
    for (int i = 0; i < 17; i++) if (v[i]) win = 5'(i);
  endfunction
  // model: r = run of identical winners while armed, q = quiet run, h = held run for repeats
  logic [16:0] s1, s2;
  logic [4:0] w, m_key;
  logic armed, m_strobe, fire_pend, skip;
  int r, q, h;
  wire m_busy = !(armed && r == 0);
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1 = '0; s2 = '0; w = '0; m_key = '0; armed = 1'b1;
      m_strobe = 1'b0; fire_pend = 1'b0; skip = 1'b0; r = 0; q = 0; h = 0;
    end else begin
      m_strobe = fire_pend;
      fire_pend = 1'b0;
      if (skip) skip = 1'b0;
      else if (armed) begin
        if (r == 0) begin
          if (s2 != 0) begin r = 1; w = win(s2); end
        end else if (s2 == 0 || win(s2) != w) r = 0;
        else begin
          r++;
          if (r == D + 1) begin
            m_key = w; armed = 1'b0; fire_pend = 1'b1; skip = 1'b1; r = 0; q = 0; h = 0;
          end
        end
      end else if (s2 == 0) begin
        q++; h = 0;
        if (q == D + 1) begin armed = 1'b1; q = 0; r = 0; end
      end else if (q > 0) begin
        q = 0; h = 0;
      end else begin
        h++;
        if (RPT && h == R && m_key != 5'd16) begin fire_pend = 1'b1; skip = 1'b1; h = 0; end
      end
      s2 = s1;
      s1 = in;
    end
  end
  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      chk("model_keyout", keyout, m_key);
      chk("model_strobe", strobe, m_strobe);
      chk("model_busy", busy, m_busy);
      if (strobe) begin nstrb++; seen.push_back(keyout); end
    end
  endtask
  initial begin
    int s, q0;
    int keys[9] = '{16, 1, 2, 3, 4, 5, 6, 7, 8};
    nrst = 1'b0; in = '0;
    cyc(2);
    chk("rst_keyout", keyout, 0); chk("rst_strobe", strobe, 0); chk("rst_busy", busy, 0);
    nrst = 1'b1;
    cyc(3);
    s = nstrb; in = 17'h8;
    cyc(6); chk("k3_e6_keyout", keyout, 0);
    cyc(1); chk("k3_e7_keyout", keyout, 3); chk("k3_e7_strobe", strobe, 0);
    cyc(1); chk("k3_e8_strobe", strobe, 1);
    cyc(1); chk("k3_e9_strobe", strobe, 0);
    cyc(11); in = '0;
    cyc(12); chk("k3_busy_end", busy, 0); chk("k3_strobes", nstrb - s, 1);
    s = nstrb; in = 17'h80;
    cyc(1); in = '0;
    cyc(1); in = 17'h80;
    cyc(6); chk("k7_e8_keyout", keyout, 3);
    cyc(1); chk("k7_e9_keyout", keyout, 7); chk("k7_e9_strobe", strobe, 0);
    cyc(1); chk("k7_e10_strobe", strobe, 1);
    cyc(10); in = '0;
    cyc(1); in = 17'h80;
    cyc(15); chk("k7_strobes", nstrb - s, 1); chk("k7_keyout", keyout, 7);
    in = '0; cyc(12);
    s = nstrb; in = 17'h10004;
    cyc(12); chk("prio_keyout", keyout, 16); chk("prio_strobes", nstrb - s, 1);
    in = '0; cyc(12);
    s = nstrb; in = 17'h2;
    cyc(10); in = 17'h202;
    cyc(10); chk("held_keyout", keyout, 1); chk("held_strobes", nstrb - s, 1);
    in = '0; cyc(12);
    s = nstrb; q0 = seen.size();
    foreach (keys[i]) begin
      in = 17'(1) << keys[i];
      cyc(10); in = '0;
      cyc(10);
    end
    chk("seq_strobes", nstrb - s, 9);
    for (int i = 0; i < 9; i++) chk($sformatf("seq_key%0d", i), (q0 + i < seen.size()) ? int'(seen[q0 + i]) : -1, keys[i]);
    in = 17'h20;
    cyc(4);
    #2 nrst = 1'b0;
    #1 chk("arst_keyout", keyout, 0); chk("arst_strobe", strobe, 0); chk("arst_busy", busy, 0);
    cyc(2);
    nrst = 1'b1; s = nstrb;
    cyc(6); chk("k5_e6_keyout", keyout, 0);
    cyc(1); chk("k5_e7_keyout", keyout, 5);
    cyc(1); chk("k5_e8_strobe", strobe, 1);
    cyc(10); in = '0;
    cyc(12); chk("k5_strobes", nstrb - s, 1);
    s = nstrb; in = 17'h10;
    cyc(60); in = '0;
    cyc(12); chk("rpt4_strobes", nstrb - s, RPT ? 4 : 1); chk("rpt4_keyout", keyout, 4);
    s = nstrb; in = 17'h10000;
    cyc(60); in = '0;
    cyc(12); chk("rpt16_strobes", nstrb - s, 1); chk("rpt16_keyout", keyout, 16);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Transmit side of the keypad unlock link. Samples 17 raw push-button lines, synchronizes and debounces them, and encodes the winning key to a 5-bit code. Codes 0–15 are digits; code 16 is the clear/reset key. Emits a one-cycle `strobe` per accepted press; the downstream unlock FSM uses `strobe` as its clock and samples `keyout` on the rising edge.

## Interface
- `DEBOUNCE_CYCLES`, default 4 — consecutive stable synchronized cycles required to accept a press or release; legal range 1..65535.
- `REPEAT_CYCLES`, default 16 — held cycles between auto-repeat strobes (used only with the macro); legal range 1..65535.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `nrst`  in  1  asynchronous active-low reset; clears every register immediately.
- `in`  in  17  raw asynchronous buttons, active-high. Bit k means key code k; bit 16 is the clear key.
- `keyout`  out  5  code of the last accepted key; held until the next accepted key.
- `strobe`  out  1  registered pulse, high exactly one cycle per accepted press (or repeat).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Two-flop synchronizer on all 17 bits feeds the logic, giving `sync`. Let `any = |sync`.
- Priority encoder: highest set index wins, so bit 16 beats everything and bit 15 beats bit 0.
- The counter is 16 bits wide and is cleared on every state change.
- **IDLE:** if `any`, latch `cand = enc(sync)`, set counter to 0, go to DEBOUNCE.
- **DEBOUNCE:**
  - If `!any` or `enc(sync) != cand`, go to IDLE.
  - Else if counter == `DEBOUNCE_CYCLES-1`: load `keyout <= cand`, go to FIRE.
  - Else counter++.
- **FIRE:** `strobe <= 1` for one cycle, then go to HELD. `keyout` therefore leads `strobe` by one full cycle, which meets downstream setup.
- **HELD:**
  - Ignores any change of key while `any` is high, including extra keys pressed.
  - If `!any`, go to RELEASE with counter 0.
- **RELEASE:**
  - If `any`, go back to HELD (treated as bounce; no new strobe).
  - Else if counter == `DEBOUNCE_CYCLES-1`, go to IDLE.
  - Else counter++.
- Simultaneous press of several keys in IDLE/DEBOUNCE: the priority winner is debounced. A change of winner mid-debounce restarts from IDLE.

## Timing
- Reset values: `keyout = 0`, `strobe = 0`, `busy = 0`, state IDLE, synchronizer flops 0, counter 0, `cand = 0`.
- Press latency: `in` stable before rising edge 1 gives:
  - `sync` valid after edge 2.
  - DEBOUNCE entered at edge 3.
  - `keyout` updated at edge `DEBOUNCE_CYCLES+3`.
  - `strobe` high after edge `DEBOUNCE_CYCLES+4` for one cycle.
  - With default 4: `keyout` at edge 7, `strobe` at edge 8.
- Minimum press-to-press spacing: release must be stable for `DEBOUNCE_CYCLES` cycles before IDLE accepts a new key.
- `nrst` asserted mid-operation drops `strobe` and `keyout` to 0 asynchronously. After release, operation starts from IDLE; a still-held key is treated as a new press.

## Configuration
- `KEYPAD_AUTOREPEAT_EN`
  - Defined: in HELD, a second counter runs while `any` remains high. Each time it reaches `REPEAT_CYCLES-1`, the block reloads `keyout` with the same code, passes through FIRE (one `strobe` pulse), returns to HELD and restarts the count. Code 16 never repeats.
  - Undefined: exactly one strobe per press regardless of hold length; `REPEAT_CYCLES` is unused.

## Test plan
- Reset: assert `nrst=0` mid-DEBOUNCE holding `in[5]` → `strobe=0`, `keyout=0` immediately; after release, `keyout=5` and one `strobe` at edge 8 (defaults).
- Clean press: `in[3]` held 20 cycles then released → exactly one strobe at edge 8, `keyout=3` from edge 7, `busy` returns to 0 after release debounce.
- Bounce: `in[7]` toggles 1,0,1 in consecutive cycles, then holds → no strobe until 4 stable cycles, then exactly one strobe with `keyout=7`; a 1-cycle release glitch during HELD → no extra strobe.
- Priority: `in[16]` and `in[2]` pressed together → `keyout=16`, one strobe. Pressing `in[9]` while `in[1]` is held → no second strobe, `keyout` stays 1.
- Sequence: press/release keys 16,1,2,3,4,5,6,7,8 with 10-cycle gaps → nine strobes; `keyout` sampled on each strobe rise matches in order.
- Auto-repeat (macro defined, `REPEAT_CYCLES=16`): hold `in[4]` for 60 cycles → strobes at edge 8, then every 17 cycles (16 held + FIRE), `keyout=4` throughout. Hold `in[16]` → single strobe. Macro undefined → single strobe for both.
